// File: rtl/y86_bus_memory.sv
// Byte-addressed RAM plus console I/O window answering the y86 core's memory bus.
// Reads are combinational in the request cycle. Writes, FIFO pushes and pops commit on the clock edge.
module y86_bus_memory #(
  parameter int          ADDR_W     = 12,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       bus_A,
  input  logic [31:0]       bus_out,
  output logic [31:0]       bus_in,
  input  logic              bus_RE,
  input  logic              bus_WE,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              fault,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int MEM_BYTES = 1 << ADDR_W;

  logic [7:0] mem [MEM_BYTES];
  logic [7:0] fifo_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             overflow;

  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]       io_off;
  logic [31:0]       ram_word;
  logic              ram_sel, io_sel, out_of_range;
  logic              empty, full;
  logic              bus_wr, push_req, push, pop, drop, bad_access;

  function automatic logic [31:0] status_word(input logic e, input logic f, input logic ov,
                                              input logic ft, input logic [PTR_W:0] occ);
    return {16'h0, 8'(occ), 4'h0, ft, ov, f, e};
  endfunction

  // Byte lanes wrap naturally at the RAM size because the lane indices are ADDR_W wide.
  assign a0 = bus_A[ADDR_W-1:0];
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);

  assign ram_sel      = (bus_A[31:ADDR_W] == '0);
  assign io_off       = bus_A - IO_BASE;
  assign io_sel       = (io_off < 32'd8);
  assign out_of_range = !ram_sel && !io_sel;
  assign ram_word     = {mem[a3], mem[a2], mem[a1], mem[a0]};

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];

  // A push into a full FIFO still lands if the same edge frees a slot.
  assign bus_wr     = bus_WE && !rst;
  assign push_req   = bus_wr && io_sel && (io_off[2:0] == 3'd0);
  assign pop        = tx_valid && tx_ready;
  assign push       = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;
  assign bad_access = ((bus_RE || bus_WE) && out_of_range) || (bus_RE && bus_WE);

  always_comb begin
    bus_in = '0;
    if (bus_RE) begin
      if (ram_sel) begin
        bus_in = ram_word;
      end else if (io_sel) begin
        case (io_off[2:0])
          3'd0:    bus_in = status_word(empty, full, overflow, fault, count);
          3'd4:    bus_in = rd_count;
          default: bus_in = '0;
        endcase
      end
    end
  end

  // RAM is never cleared; the loader port owns it while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (ld_we) mem[ld_addr] <= ld_data;
    end else if (bus_WE && ram_sel) begin
      mem[a0] <= bus_out[7:0];
      mem[a1] <= bus_out[15:8];
      mem[a2] <= bus_out[23:16];
      mem[a3] <= bus_out[31:24];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus_out[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      fault    <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop)       overflow <= 1'b1;
      if (bad_access) fault    <= 1'b1;
      if (bus_RE)     rd_count <= rd_count + 32'd1;
      if (bus_WE)     wr_count <= wr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_y86_bus_memory.sv
// Directed bench for y86_bus_memory: loader, unaligned/wrapping RAM, console FIFO, faults, collisions.
module tb_y86_bus_memory;

  localparam int          ADDR_W  = 12;
  localparam logic [31:0] IO_BASE = 32'hFFFF_FF00;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       bus_A;
  logic [31:0]       bus_out;
  logic [31:0]       bus_in;
  logic              bus_RE;
  logic              bus_WE;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              fault;
  logic [31:0]       rd_count;
  logic [31:0]       wr_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_rd = 0;
  logic [31:0] exp_wr = 0;

  y86_bus_memory #(.ADDR_W(ADDR_W), .IO_BASE(IO_BASE), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .bus_A(bus_A), .bus_out(bus_out), .bus_in(bus_in),
    .bus_RE(bus_RE), .bus_WE(bus_WE), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .fault(fault),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus_A = addr; bus_RE = 1'b1; bus_WE = 1'b0;
    #1 chk(tag, bus_in, exp);
    tick();
    bus_RE = 1'b0;
    exp_rd++;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_A = addr; bus_out = data; bus_WE = 1'b1; bus_RE = 1'b0;
    tick();
    bus_WE = 1'b0;
    exp_wr++;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_rd"}, rd_count, exp_rd);
    chk({tag, "_wr"}, wr_count, exp_wr);
  endtask

  logic [7:0] init_bytes [12];
  logic [7:0] drain_exp  [8];

  initial begin
    rst = 1'b1; bus_A = '0; bus_out = '0; bus_RE = 1'b0; bus_WE = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0; tx_ready = 1'b0;
    init_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00};
    drain_exp  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h39};
    tick(); tick();

    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk_counts("rst_cnt");

    // Loader while in reset
    for (int i = 0; i < 12; i++) begin
      ld_we = 1'b1; ld_addr = ADDR_W'(i); ld_data = init_bytes[i];
      tick();
    end
    ld_we = 1'b0;
    // bus_WE must be ignored during reset
    bus_A = 32'd8; bus_out = 32'hDEAD_BEEF; bus_WE = 1'b1;
    tick();
    bus_WE = 1'b0;
    chk("rst_wr_cnt", wr_count, 32'd0);

    rst = 1'b0;
    tick();
    bus_A = 32'd1; bus_RE = 1'b0;
    #1 chk("re_low_zero", bus_in, 32'd0);
    bus_read("unaligned_rd", 32'd1, 32'h5544_3322);
    chk("rd_count_one", rd_count, 32'd1);
    bus_read("rst_we_ignored", 32'd8, 32'h0000_0000);

    // Loader outside reset is ignored
    ld_we = 1'b1; ld_addr = ADDR_W'(8); ld_data = 8'h77;
    tick();
    ld_we = 1'b0;
    bus_read("ld_no_rst_ignored", 32'd8, 32'h0000_0000);

    // Wrap at top of RAM
    bus_write(32'h0000_0FFE, 32'hAABB_CCDD);
    bus_read("wrap_rd_ffe", 32'h0000_0FFE, 32'hAABB_CCDD);
    bus_read("wrap_rd_0", 32'h0000_0000, 32'h4433_AABB);
    bus_write(32'h0000_0100, 32'h0102_0304);
    bus_read("wr_then_rd", 32'h0000_0100, 32'h0102_0304);
    chk_counts("after_ram");

    // Console
    bus_read("status_empty", IO_BASE, 32'h0000_0001);
    bus_write(IO_BASE, 32'h0000_0048);
    chk("push_lat_valid", {31'b0, tx_valid}, 32'd1);
    bus_write(IO_BASE, 32'h0000_0069);
    bus_write(IO_BASE + 32'd3, 32'h0000_00EE);
    chk("tx_data_H", {24'b0, tx_data}, 32'h48);
    bus_read("status_two", IO_BASE, 32'h0000_0200);
    bus_read("io_rd_count", IO_BASE + 32'd4, exp_rd);
    bus_read("io_other_zero", IO_BASE + 32'd2, 32'd0);
    chk("io_no_fault", {31'b0, fault}, 32'd0);
    tx_ready = 1'b1;
    tick();
    chk("pop_i_valid", {31'b0, tx_valid}, 32'd1);
    chk("pop_i_data", {24'b0, tx_data}, 32'h69);
    tick();
    chk("drained", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Overflow: nine pushes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) bus_write(IO_BASE, 32'h30 + i);
    bus_read("status_full_ovf", IO_BASE, 32'h0000_0806);
    chk("full_head", {24'b0, tx_data}, 32'h30);
    tx_ready = 1'b1;
    bus_write(IO_BASE, 32'h0000_0039);
    tx_ready = 1'b0;
    bus_read("push_pop_full", IO_BASE, 32'h0000_0806);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), {24'b0, tx_data}, {24'b0, drain_exp[i]});
      tick();
    end
    tick();
    tx_ready = 1'b0;
    bus_read("status_ovf_empty", IO_BASE, 32'h0000_0005);
    chk_counts("after_io");

    // Fault behaviour
    bus_read("oor_rd_zero", 32'h0001_0000, 32'd0);
    chk("fault_set", {31'b0, fault}, 32'd1);
    bus_read("io_gap_zero", IO_BASE + 32'd8, 32'd0);
    tick();
    chk("fault_sticky", {31'b0, fault}, 32'd1);
    bus_read("status_fault", IO_BASE, 32'h0000_000D);
    rst = 1'b1;
    bus_A = 32'd2; bus_RE = 1'b1;
    #1 chk("rd_during_rst", bus_in, 32'h0055_4433);
    tick();
    bus_RE = 1'b0;
    rst = 1'b0;
    exp_rd = 0; exp_wr = 0;
    chk("fault_cleared", {31'b0, fault}, 32'd0);
    chk_counts("rst2_cnt");
    bus_read("status_after_rst", IO_BASE, 32'h0000_0001);
    bus_read("ram_kept", 32'd2, 32'h0055_4433);

    // RE and WE together
    bus_write(32'd4, 32'h0000_0000);
    chk("pre_coll_fault", {31'b0, fault}, 32'd0);
    bus_A = 32'd4; bus_out = 32'h0000_1234; bus_RE = 1'b1; bus_WE = 1'b1;
    #1 chk("coll_old_data", bus_in, 32'd0);
    tick();
    bus_RE = 1'b0; bus_WE = 1'b0;
    exp_rd++; exp_wr++;
    chk("coll_fault", {31'b0, fault}, 32'd1);
    chk_counts("coll_cnt");
    bus_read("coll_new_data", 32'd4, 32'h0000_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
